// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes op classes into ALU selects, holds an EX stage that
// drives the combinational ALU and an OUT stage that registers its result for MEM.
module alu_issue_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [3:0]    op_i,
    input  logic [N-1:0]  rs1_i,
    input  logic [N-1:0]  rs2_i,
    input  logic [N-1:0]  imm_i,
    input  logic          use_imm_i,
    input  logic [4:0]    rd_i,
    output logic [2:0]    alu_sel_o,
    output logic [N-1:0]  alu_a_o,
    output logic [N-1:0]  alu_b_o,
    input  logic [N-1:0]  alu_s_i,
    input  logic          alu_z_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [N-1:0]  result_o,
    output logic [4:0]    rd_o,
    output logic          illegal_o,
    output logic          branch_taken_o,
    output logic [CW-1:0] retired_o
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_BEQ = 4'd6;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SUB  = 3'b001;
    localparam logic [2:0] SEL_AND  = 3'b010;
    localparam logic [2:0] SEL_OR   = 3'b011;
    localparam logic [2:0] SEL_SLT  = 3'b101;
    localparam logic [2:0] SEL_SLL  = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;

    typedef enum logic {
        EX_EMPTY = 1'b0,
        EX_FULL  = 1'b1
    } ex_state_e;

    ex_state_e       ex_state_q, ex_state_d;
    logic [2:0]      ex_sel_q, ex_sel_d;
    logic [N-1:0]    ex_a_q, ex_a_d;
    logic [N-1:0]    ex_b_q, ex_b_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_beq_q, ex_beq_d;
    logic            ex_illegal_q, ex_illegal_d;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_result_q, out_result_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_illegal_q, out_illegal_d;

    logic [CW-1:0]   retired_q, retired_d;

    logic [2:0]      dec_sel;
    logic [N-1:0]    dec_b;
    logic            dec_beq;
    logic            dec_illegal;

    logic            ex_valid;
    logic            ex_adv;
    logic            transfer;
    logic            taken;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dec_sel     = SEL_NONE;
        dec_beq     = 1'b0;
        dec_illegal = 1'b0;
        dec_b       = use_imm_i ? imm_i : rs2_i;
        case (op_i)
            OP_ADD: dec_sel = SEL_ADD;
            OP_SUB: dec_sel = SEL_SUB;
            OP_AND: dec_sel = SEL_AND;
            OP_OR:  dec_sel = SEL_OR;
            OP_SLT: dec_sel = SEL_SLT;
            OP_SLL: dec_sel = SEL_SLL;
            OP_BEQ: begin
                dec_sel = SEL_SUB;
                dec_beq = 1'b1;
                dec_b   = rs2_i;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign ex_valid = (ex_state_q == EX_FULL);
    assign ex_adv   = ex_valid && (!out_valid_q || ready_i);
    assign ready_o  = !ex_valid || ex_adv;
    assign transfer = valid_i && ready_o;
    // A taken BEQ squashes whatever ID hands over in the same cycle.
    assign taken    = ex_adv && ex_beq_q && alu_z_i;

    always_comb begin
        ex_state_d   = ex_state_q;
        ex_sel_d     = ex_sel_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_rd_d      = ex_rd_q;
        ex_beq_d     = ex_beq_q;
        ex_illegal_d = ex_illegal_q;
        case (ex_state_q)
            EX_EMPTY: begin
                if (transfer) begin
                    ex_state_d = EX_FULL;
                end
            end
            EX_FULL: begin
                if (ex_adv && (!transfer || taken)) begin
                    ex_state_d = EX_EMPTY;
                end
            end
            default: ex_state_d = EX_EMPTY;
        endcase
        if (transfer && !taken) begin
            ex_sel_d     = dec_sel;
            ex_a_d       = rs1_i;
            ex_b_d       = dec_b;
            ex_rd_d      = rd_i;
            ex_beq_d     = dec_beq;
            ex_illegal_d = dec_illegal;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (ex_adv && !ex_beq_q) begin
            out_valid_d   = 1'b1;
            out_result_d  = ex_illegal_q ? '0 : alu_s_i;
            out_rd_d      = ex_rd_q;
            out_illegal_d = ex_illegal_q;
        end else if (ready_i) begin
            out_valid_d   = 1'b0;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (out_valid_q && ready_i && (retired_q != '1)) begin
            retired_d = retired_q + CW'(1);
        end
    end

    // NOTE: datapath registers are reset as well so the ALU sees SEL_NONE and zero operands out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_state_q    <= EX_EMPTY;
            ex_sel_q      <= SEL_NONE;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_rd_q       <= '0;
            ex_beq_q      <= 1'b0;
            ex_illegal_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            ex_state_q    <= ex_state_d;
            ex_sel_q      <= ex_sel_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_rd_q       <= ex_rd_d;
            ex_beq_q      <= ex_beq_d;
            ex_illegal_q  <= ex_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
            retired_q     <= retired_d;
        end
    end

    assign alu_sel_o      = ex_sel_q;
    assign alu_a_o        = ex_a_q;
    assign alu_b_o        = ex_b_q;
    assign valid_o        = out_valid_q;
    assign result_o       = out_result_q;
    assign rd_o           = out_rd_q;
    assign illegal_o      = out_illegal_q;
    assign branch_taken_o = taken;
    assign retired_o      = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU closes the loop, expected
// writebacks are queued at issue and popped whenever valid_o && ready_i.
module tb_alu_issue_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;

    typedef struct {
        logic [N-1:0] result;
        logic [4:0]   rd;
        logic         illegal;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [3:0]    op_i = '0;
    logic [N-1:0]  rs1_i = '0, rs2_i = '0, imm_i = '0;
    logic          use_imm_i = 1'b0;
    logic [4:0]    rd_i = '0;
    logic [2:0]    alu_sel_o;
    logic [N-1:0]  alu_a_o, alu_b_o;
    logic [N-1:0]  alu_s_i;
    logic          alu_z_i;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [N-1:0]  result_o;
    logic [4:0]    rd_o;
    logic          illegal_o;
    logic          branch_taken_o;
    logic [CW-1:0] retired_o;

    int   errors = 0;
    int   checks = 0;
    int   branch_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_issue_ctrl #(.N(N), .CW(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .use_imm_i(use_imm_i),
        .rd_i(rd_i), .alu_sel_o(alu_sel_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_s_i(alu_s_i), .alu_z_i(alu_z_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .rd_o(rd_o), .illegal_o(illegal_o),
        .branch_taken_o(branch_taken_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU driven by the DUT select/operands.
    always_comb begin
        alu_s_i = '0;
        case (alu_sel_o)
            3'b000: alu_s_i = alu_a_o + alu_b_o;
            3'b001: alu_s_i = alu_a_o - alu_b_o;
            3'b010: alu_s_i = alu_a_o & alu_b_o;
            3'b011: alu_s_i = alu_a_o | alu_b_o;
            3'b101: alu_s_i = (alu_a_o < alu_b_o) ? N'(1) : '0;
            3'b110: alu_s_i = alu_a_o << alu_b_o;
            default: alu_s_i = '0;
        endcase
        alu_z_i = (alu_sel_o != 3'b111) && (alu_s_i == '0);
    end

    function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (a < b) ? N'(1) : '0;
            4'd5: r = a << b;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (branch_taken_o) branch_cnt++;
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid_o: got result=%0d rd=%0d illegal=%0b, expected none",
                             result_o, rd_o, illegal_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({result_o, rd_o, illegal_o} !== {mon_e.result, mon_e.rd, mon_e.illegal}) begin
                        errors++;
                        $display("FAIL writeback: got result=%0d rd=%0d illegal=%0b, expected result=%0d rd=%0d illegal=%0b",
                                 result_o, rd_o, illegal_o, mon_e.result, mon_e.rd, mon_e.illegal);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] imm, input logic ui, input logic [4:0] rd,
                         input bit push, output int waited);
        logic [N-1:0] b_eff;
        exp_t e;
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; imm_i = imm; use_imm_i = ui; rd_i = rd;
        waited = 0;
        @(negedge clk_i);
        while (!ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL issue_timeout: ready_o=%0b after %0d cycles, expected 1", ready_o, waited);
        end else if (push) begin
            b_eff = (ui && op != 4'd6) ? imm : b;
            e.result = model(op, a, b_eff);
            e.rd = rd;
            e.illegal = (op > 4'd6);
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic check_retired(input string name, input int expv);
        checks++;
        if (retired_o !== CW'(expv)) begin
            errors++;
            $display("FAIL %s: retired_o=%0d expected %0d", name, retired_o, expv);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({ready_o, valid_o, illegal_o, branch_taken_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/illegal/branch=%b expected 1000",
                     {ready_o, valid_o, illegal_o, branch_taken_o});
        end
        checks++;
        if ({alu_sel_o, alu_a_o, alu_b_o} !== {3'b111, {N{1'b0}}, {N{1'b0}}}) begin
            errors++;
            $display("FAIL reset_alu: sel=%b a=%0d b=%0d expected sel=111 a=0 b=0", alu_sel_o, alu_a_o, alu_b_o);
        end
        checks++;
        if ({result_o, rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%0d rd=%0d expected 0 0", result_o, rd_o);
        end
        check_retired("reset_retired", 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_add();
        int w;
        issue(4'd0, 4'd3, 4'd5, 4'd9, 1'b0, 5'd5, 1'b1, w);
        @(negedge clk_i);
        checks++;
        if ({alu_sel_o, alu_a_o, alu_b_o, valid_o} !== {3'b000, 4'd3, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL add_ex: sel=%b a=%0d b=%0d valid=%0b expected sel=000 a=3 b=5 valid=0",
                     alu_sel_o, alu_a_o, alu_b_o, valid_o);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o, rd_o} !== {1'b1, 4'd8, 5'd5}) begin
            errors++;
            $display("FAIL add_out: valid=%0b result=%0d rd=%0d expected 1 8 5", valid_o, result_o, rd_o);
        end
        drain();
        check_retired("add_retired", 1);
    endtask

    task automatic test_back_to_back();
        int w, tw;
        tw = 0;
        issue(4'd1, 4'd7, 4'd7, 4'd0, 1'b0, 5'd1, 1'b1, w); tw += w;
        issue(4'd3, 4'd4, 4'd8, 4'd1, 1'b1, 5'd2, 1'b1, w); tw += w;
        issue(4'd5, 4'd1, 4'd2, 4'd0, 1'b0, 5'd3, 1'b1, w); tw += w;
        issue(4'd4, 4'd2, 4'd3, 4'd0, 1'b0, 5'd4, 1'b1, w); tw += w;
        checks++;
        if (tw != 0) begin
            errors++;
            $display("FAIL b2b_ready: ready_o low for %0d cycles, expected 0", tw);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL b2b_third: valid=%0b result=%0d expected 1 4", valid_o, result_o);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL b2b_fourth: valid=%0b result=%0d expected 1 1", valid_o, result_o);
        end
        drain();
        check_retired("b2b_retired", 5);
    endtask

    task automatic test_stall();
        int w;
        ready_i = 1'b0;
        fork
            begin
                issue(4'd0, 4'd2, 4'd3, 4'd0, 1'b0, 5'd1, 1'b1, w);
                issue(4'd2, 4'd6, 4'd3, 4'd0, 1'b0, 5'd2, 1'b1, w);
                issue(4'd1, 4'd1, 4'd2, 4'd0, 1'b0, 5'd3, 1'b1, w);
            end
            begin
                repeat (2) @(posedge clk_i);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk_i);
                    checks++;
                    if ({valid_o, result_o, rd_o, ready_o} !== {1'b1, 4'd5, 5'd1, 1'b0}) begin
                        errors++;
                        $display("FAIL stall_hold%0d: valid=%0b result=%0d rd=%0d ready_o=%0b expected 1 5 1 0",
                                 k, valid_o, result_o, rd_o, ready_o);
                    end
                end
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();
        check_retired("stall_retired", 8);
    endtask

    task automatic test_branch();
        int w, b0;
        b0 = branch_cnt;
        issue(4'd6, 4'd6, 4'd6, 4'd0, 1'b1, 5'd9, 1'b0, w);
        issue(4'd0, 4'd1, 4'd1, 4'd0, 1'b0, 5'd10, 1'b0, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL beq_ready: ready_o low for %0d cycles during taken BEQ, expected 0", w);
        end
        drain();
        checks++;
        if (branch_cnt - b0 != 1) begin
            errors++;
            $display("FAIL beq_taken_pulses: got %0d expected 1", branch_cnt - b0);
        end
        check_retired("beq_taken_retired", 8);
        b0 = branch_cnt;
        issue(4'd6, 4'd6, 4'd5, 4'd6, 1'b1, 5'd9, 1'b0, w);
        issue(4'd0, 4'd1, 4'd1, 4'd0, 1'b0, 5'd11, 1'b1, w);
        drain();
        checks++;
        if (branch_cnt - b0 != 0) begin
            errors++;
            $display("FAIL beq_not_taken_pulses: got %0d expected 0", branch_cnt - b0);
        end
        check_retired("beq_not_taken_retired", 9);
    endtask

    task automatic test_illegal_wrap();
        int w;
        issue(4'd9, 4'd5, 4'd3, 4'd0, 1'b0, 5'd7, 1'b1, w);
        issue(4'd0, 4'd15, 4'd1, 4'd0, 1'b0, 5'd8, 1'b1, w);
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o, illegal_o, rd_o} !== {1'b1, 4'd0, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL illegal_out: valid=%0b result=%0d illegal=%0b rd=%0d expected 1 0 1 7",
                     valid_o, result_o, illegal_o, rd_o);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o, illegal_o, rd_o} !== {1'b1, 4'd0, 1'b0, 5'd8}) begin
            errors++;
            $display("FAIL wrap_out: valid=%0b result=%0d illegal=%0b rd=%0d expected 1 0 0 8",
                     valid_o, result_o, illegal_o, rd_o);
        end
        drain();
        check_retired("illegal_retired", 11);
    endtask

    task automatic test_reset_mid();
        int w;
        ready_i = 1'b0;
        issue(4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 5'd1, 1'b1, w);
        issue(4'd3, 4'd1, 4'd2, 4'd0, 1'b0, 5'd2, 1'b1, w);
        @(negedge clk_i);
        checks++;
        if ({valid_o, ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_full: valid=%0b ready_o=%0b expected 1 0", valid_o, ready_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, ready_o, branch_taken_o, alu_sel_o, result_o, rd_o} !== {3'b010, 3'b111, {N{1'b0}}, 5'd0}) begin
            errors++;
            $display("FAIL rstmid_clear: valid=%0b ready_o=%0b branch=%0b sel=%b result=%0d rd=%0d expected 0 1 0 111 0 0",
                     valid_o, ready_o, branch_taken_o, alu_sel_o, result_o, rd_o);
        end
        check_retired("rstmid_retired", 0);
        exp_q.delete();
        ready_i = 1'b1;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        issue(4'd0, 4'd3, 4'd4, 4'd0, 1'b0, 5'd12, 1'b1, w);
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_lat1: valid=%0b expected 0", valid_o);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, result_o} !== {1'b1, 4'd7}) begin
            errors++;
            $display("FAIL rstmid_lat2: valid=%0b result=%0d expected 1 7", valid_o, result_o);
        end
        drain();
        check_retired("rstmid_after", 1);
    endtask

    task automatic test_saturation();
        int w;
        for (int i = 0; i < 260; i++) begin
            issue(4'd0, N'(i), 4'd1, 4'd0, 1'b0, 5'(i), 1'b1, w);
        end
        drain();
        check_retired("retired_saturate", 255);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_branch();
        test_illegal_wrap();
        test_reset_mid();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d writebacks missing, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
